frame_wr_ctrl: RTL and testbench

Write-side controller of the frame buffer. It accepts the incoming 64-bit video stream (tuser = start of frame, tlast = end of line) and writes each line into one of FRAMES_AMOUNT rotating frame buffers in memory as fixed-length AXI4 INCR bursts. After the last write response of a frame it emits the wr_done strobe for the read controller, and it consumes that controller's rd_done strobe so it never overwrites a buffer that is still occupied.

---
 rtl/frame_wr_ctrl.sv | 263 ++++++++++++++++++++++++++
 tb/tb_frame_wr_ctrl.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_wr_ctrl.sv
// frame_wr_ctrl: write side of the frame buffer.
//
// Takes a 64-bit video stream (tuser = start of frame, tlast = end of line) and writes
// every line into one of FRAMES_AMOUNT rotating buffers as fixed-length AXI4 INCR bursts.
// After the last write response of a frame it pulses wr_done_stb_o. It also tracks the
// reader's rd_done_stb_i so a buffer still in use is never overwritten.
//
// Ports:
//   clk_i, rst_n_i         clock, asynchronous active-low reset
//   video_*                AXI4-Stream slave (tdata 64, tuser, tlast, tvalid/tready)
//   mem_aw*, mem_w*, mem_b* AXI4 write channels (master)
//   mem_arvalid_o, mem_rready_o  read channels, tied inactive
//   wr_done_stb_o          pulse: frame written and fully acknowledged
//   rd_done_stb_i          pulse from reader: it finished reading a frame
//   frame_drop_o           pulse: incoming frame discarded, no free buffer
//   sync_err_o             pulse: framing error in the stream
module frame_wr_ctrl #(
  parameter int unsigned START_ADDR      = 0,
  parameter int unsigned FRAMES_AMOUNT   = 3,
  parameter int unsigned FRAME_RES_Y     = 1080,
  parameter int unsigned FRAME_RES_X     = 1920,
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned BURST_WORDS     = 16,
  parameter int unsigned MAX_OUTSTANDING = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic [63:0]           video_tdata_i,
  input  logic                  video_tvalid_i,
  input  logic                  video_tuser_i,
  input  logic                  video_tlast_i,
  output logic                  video_tready_o,
  output logic [ADDR_WIDTH-1:0] mem_awaddr_o,
  output logic [7:0]            mem_awlen_o,
  output logic [2:0]            mem_awsize_o,
  output logic [1:0]            mem_awburst_o,
  output logic [3:0]            mem_awid_o,
  output logic                  mem_awvalid_o,
  input  logic                  mem_awready_i,
  output logic [63:0]           mem_wdata_o,
  output logic [7:0]            mem_wstrb_o,
  output logic                  mem_wlast_o,
  output logic                  mem_wvalid_o,
  input  logic                  mem_wready_i,
  input  logic                  mem_bvalid_i,
  output logic                  mem_bready_o,
  output logic                  mem_arvalid_o,
  output logic                  mem_rready_o,
  output logic                  wr_done_stb_o,
  input  logic                  rd_done_stb_i,
  output logic                  frame_drop_o,
  output logic                  sync_err_o
);

  localparam int unsigned WPL         = (FRAME_RES_X + 3) / 4;
  localparam int unsigned BPL         = WPL * 8;
  localparam int unsigned BPF         = BPL * FRAME_RES_Y;
  localparam int unsigned BURST_BYTES = BURST_WORDS * 8;
  localparam int unsigned WORD_W      = $clog2(WPL + 1);
  localparam int unsigned LINE_W      = $clog2(FRAME_RES_Y + 1);
  localparam int unsigned BEAT_W      = $clog2(BURST_WORDS + 1);
  localparam int unsigned OUT_W       = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned IDX_W       = $clog2(FRAMES_AMOUNT + 1);

  if ((START_ADDR % 4096) != 0) begin : g_bad_start
    $error("frame_wr_ctrl: START_ADDR must be 4 KiB aligned");
  end
  if (((4096 % BURST_BYTES) != 0) || ((BPL % BURST_BYTES) != 0)) begin : g_bad_burst
    $error("frame_wr_ctrl: BURST_WORDS*8 must divide 4096 and the line size");
  end
  if (FRAMES_AMOUNT < 2) begin : g_bad_frames
    $error("frame_wr_ctrl: FRAMES_AMOUNT must be at least 2");
  end

  typedef enum logic [2:0] {StWaitSof, StAddr, StData, StFlush, StDrop, StWaitB} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [IDX_W-1:0]      idx_q, avail_q;
  logic [OUT_W-1:0]      outstanding_q;
  logic [BEAT_W-1:0]     beat_q, beat_d;
  logic [WORD_W-1:0]     word_q, word_d;
  logic [LINE_W-1:0]     line_q, line_d;
  logic                  first_q, first_d;
  logic                  flush_to_drop_q, flush_to_drop_d;
  // Keeps tready low while reset is asserted.
  logic                  active_q;

  logic last_beat, last_word, last_line, sof_seen, aw_hs, wr_done;

  assign last_beat = (beat_q == BEAT_W'(BURST_WORDS - 1));
  assign last_word = (word_q == WORD_W'(WPL - 1));
  assign last_line = (line_q == LINE_W'(FRAME_RES_Y - 1));
  assign sof_seen  = video_tvalid_i && video_tuser_i;
  assign aw_hs     = mem_awvalid_o && mem_awready_i;

  assign mem_awaddr_o  = addr_q;
  assign mem_awlen_o   = 8'(BURST_WORDS - 1);
  assign mem_awsize_o  = 3'd3;
  assign mem_awburst_o = 2'b01;
  assign mem_awid_o    = 4'd0;
  assign mem_wdata_o   = video_tdata_i;
  assign mem_wlast_o   = last_beat;
  assign mem_bready_o  = 1'b1;
  assign mem_arvalid_o = 1'b0;
  assign mem_rready_o  = 1'b0;
  assign wr_done_stb_o = wr_done;

  always_comb begin
    state_d         = state_q;
    addr_d          = addr_q;
    beat_d          = beat_q;
    word_d          = word_q;
    line_d          = line_q;
    first_d         = first_q;
    flush_to_drop_d = flush_to_drop_q;
    video_tready_o  = 1'b0;
    mem_awvalid_o   = 1'b0;
    mem_wvalid_o    = 1'b0;
    mem_wstrb_o     = 8'hFF;
    wr_done         = 1'b0;
    frame_drop_o    = 1'b0;
    sync_err_o      = 1'b0;

    unique case (state_q)
      StWaitSof, StDrop: begin
        video_tready_o = active_q;
        if (active_q && sof_seen) begin
          if (avail_q == IDX_W'(FRAMES_AMOUNT)) begin
            // No free buffer: swallow the SOF beat and skip the whole frame.
            frame_drop_o = 1'b1;
            state_d      = StDrop;
          end else begin
            // Leave the SOF beat in the stream; it becomes the first W beat.
            video_tready_o = 1'b0;
            state_d        = StAddr;
            first_d        = 1'b1;
            beat_d         = '0;
            word_d         = '0;
            line_d         = '0;
            addr_d         = base_q;
          end
        end
      end

      StAddr: begin
        mem_awvalid_o = (outstanding_q != OUT_W'(MAX_OUTSTANDING));
        if (aw_hs) begin
          addr_d  = addr_q + ADDR_WIDTH'(BURST_BYTES);
          state_d = StData;
        end
      end

      StData: begin
        if (sof_seen && !first_q) begin
          // Unexpected SOF: hold the beat back for the next frame and pad this burst.
          sync_err_o      = 1'b1;
          flush_to_drop_d = 1'b0;
          state_d         = StFlush;
        end else begin
          mem_wvalid_o   = video_tvalid_i;
          video_tready_o = mem_wready_i;
          if (video_tvalid_i && mem_wready_i) begin
            first_d = 1'b0;
            beat_d  = last_beat ? '0 : beat_q + BEAT_W'(1);
            word_d  = word_q + WORD_W'(1);
            if (video_tlast_i && !last_word) begin
              sync_err_o = 1'b1;
              if (last_beat) begin
                state_d = StDrop;
              end else begin
                flush_to_drop_d = 1'b1;
                state_d         = StFlush;
              end
            end else if (!video_tlast_i && last_word) begin
              // The line's last word always closes a burst, so nothing to pad.
              sync_err_o = 1'b1;
              state_d    = StDrop;
            end else if (last_word) begin
              word_d  = '0;
              line_d  = line_q + LINE_W'(1);
              state_d = last_line ? StWaitB : StAddr;
            end else if (last_beat) begin
              state_d = StAddr;
            end
          end
        end
      end

      StFlush: begin
        mem_wvalid_o = 1'b1;
        mem_wstrb_o  = 8'h00;
        if (mem_wready_i) begin
          beat_d = beat_q + BEAT_W'(1);
          if (last_beat) begin
            beat_d  = '0;
            state_d = flush_to_drop_q ? StDrop : StWaitSof;
          end
        end
      end

      StWaitB: begin
        if (outstanding_q == '0) begin
          wr_done = 1'b1;
          state_d = StWaitSof;
        end
      end

      default: state_d = StWaitSof;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q         <= StWaitSof;
      addr_q          <= ADDR_WIDTH'(START_ADDR);
      base_q          <= ADDR_WIDTH'(START_ADDR);
      idx_q           <= '0;
      avail_q         <= '0;
      outstanding_q   <= '0;
      beat_q          <= '0;
      word_q          <= '0;
      line_q          <= '0;
      first_q         <= 1'b0;
      flush_to_drop_q <= 1'b0;
      active_q        <= 1'b0;
    end else begin
      state_q         <= state_d;
      addr_q          <= addr_d;
      beat_q          <= beat_d;
      word_q          <= word_d;
      line_q          <= line_d;
      first_q         <= first_d;
      flush_to_drop_q <= flush_to_drop_d;
      active_q        <= 1'b1;

      if (wr_done) begin
        if (idx_q == IDX_W'(FRAMES_AMOUNT - 1)) begin
          idx_q  <= '0;
          base_q <= ADDR_WIDTH'(START_ADDR);
        end else begin
          idx_q  <= idx_q + IDX_W'(1);
          base_q <= base_q + ADDR_WIDTH'(BPF);
        end
      end

      // The reader always keeps its last frame, so the count never drops below 1.
      if (wr_done && !rd_done_stb_i) begin
        avail_q <= avail_q + IDX_W'(1);
      end else if (!wr_done && rd_done_stb_i && (avail_q > IDX_W'(1))) begin
        avail_q <= avail_q - IDX_W'(1);
      end

      if (aw_hs && !mem_bvalid_i) begin
        outstanding_q <= outstanding_q + OUT_W'(1);
      end else if (!aw_hs && mem_bvalid_i && (outstanding_q != '0)) begin
        outstanding_q <= outstanding_q - OUT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_frame_wr_ctrl.sv
module tb_frame_wr_ctrl;

  localparam int MAXO = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [63:0] tdata = '0;
  logic        tvalid = 1'b0, tuser = 1'b0, tlast = 1'b0, tready;
  logic [31:0] awaddr;
  logic [7:0]  awlen, wstrb;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic [3:0]  awid;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic [63:0] wdata;
  logic        arvalid, rready, wr_done, rd_done = 1'b0, frame_drop, sync_err;

  frame_wr_ctrl #(
    .START_ADDR     (32'h1000),
    .FRAMES_AMOUNT  (3),
    .FRAME_RES_Y    (4),
    .FRAME_RES_X    (64),
    .ADDR_WIDTH     (32),
    .BURST_WORDS    (8),
    .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clk_i         (clk),
    .rst_n_i       (rst_n),
    .video_tdata_i (tdata),
    .video_tvalid_i(tvalid),
    .video_tuser_i (tuser),
    .video_tlast_i (tlast),
    .video_tready_o(tready),
    .mem_awaddr_o  (awaddr),
    .mem_awlen_o   (awlen),
    .mem_awsize_o  (awsize),
    .mem_awburst_o (awburst),
    .mem_awid_o    (awid),
    .mem_awvalid_o (awvalid),
    .mem_awready_i (awready),
    .mem_wdata_o   (wdata),
    .mem_wstrb_o   (wstrb),
    .mem_wlast_o   (wlast),
    .mem_wvalid_o  (wvalid),
    .mem_wready_i  (wready),
    .mem_bvalid_i  (bvalid),
    .mem_bready_o  (bready),
    .mem_arvalid_o (arvalid),
    .mem_rready_o  (rready),
    .wr_done_stb_o (wr_done),
    .rd_done_stb_i (rd_done),
    .frame_drop_o  (frame_drop),
    .sync_err_o    (sync_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {logic [63:0] d; logic [7:0] s; logic l;} wexp_t;

  logic [31:0] exp_aw[$];
  wexp_t       exp_w[$];
  int          bq[$];
  int n_checks = 0, n_err = 0;
  int cyc = 0;
  int aw_delay = 0, b_delay = 2;
  bit wr_pat = 0;
  int aw_hs_mon = 0, b_hs_mon = 0, model_out = 0;
  int done_cnt = 0, drop_cnt = 0, err_cnt = 0, aw_total = 0;
  int exp_done = 0, exp_drop = 0, exp_err = 0, exp_aw_total = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  function automatic void fail_now(string name);
    n_checks++;
    n_err++;
    $display("FAIL %s: got event expected none/in-time", name);
  endfunction

  // Memory model: AW ready after aw_delay cycles, B returned b_delay cycles after wlast.
  initial begin
    int aw_seen = 0, b_seen = 0, aw_wait = 0;
    awready = 1'b0;
    bvalid  = 1'b0;
    wready  = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        awready = 1'b0;
        bvalid  = 1'b0;
        bq.delete();
        aw_wait = 0;
        aw_seen = aw_hs_mon;
        b_seen  = b_hs_mon;
        continue;
      end
      if (aw_hs_mon != aw_seen) begin
        aw_seen = aw_hs_mon;
        awready = 1'b0;
        aw_wait = 0;
      end
      if (awvalid && !awready) begin
        if (aw_wait >= aw_delay) awready = 1'b1;
        else aw_wait++;
      end
      if (b_hs_mon != b_seen) begin
        b_seen = b_hs_mon;
        bvalid = 1'b0;
        void'(bq.pop_front());
      end
      if (!bvalid && (bq.size() > 0) && (bq[0] <= cyc)) bvalid = 1'b1;
      wready = wr_pat ? ((cyc % 3) != 0) : 1'b1;
    end
  end

  // Monitor / scoreboard: samples on the falling edge, pops expectations per handshake.
  initial begin
    logic [31:0] a;
    wexp_t       e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        model_out = 0;
        continue;
      end
      if (awvalid && awready) begin
        aw_hs_mon++;
        aw_total++;
        model_out++;
        check("outstanding_le_max", 64'(model_out <= MAXO), 64'd1);
        if (exp_aw.size() == 0) begin
          fail_now("aw_unexpected");
        end else begin
          a = exp_aw.pop_front();
          check("awaddr", 64'(awaddr), 64'(a));
          check("awlen", 64'(awlen), 64'd7);
          check("awsize_burst_id", {awsize, awburst, awid}, {3'd3, 2'd1, 4'd0});
        end
      end
      if (wvalid && wready) begin
        if (exp_w.size() == 0) begin
          fail_now("w_unexpected");
        end else begin
          e = exp_w.pop_front();
          check("wstrb_wlast", {wstrb, wlast}, {e.s, e.l});
          if (e.s != 8'h00) check("wdata", wdata, e.d);
        end
        if (wlast) bq.push_back(cyc + b_delay);
      end
      if (bvalid && bready) begin
        b_hs_mon++;
        model_out--;
      end
      if (wr_done) begin
        done_cnt++;
        check("wr_done_after_last_b", 64'(model_out), 64'd0);
      end
      if (frame_drop) drop_cnt++;
      if (sync_err) err_cnt++;
    end
  end

  task automatic send(input logic [63:0] d, input logic u, input logic l);
    int n;
    n = 0;
    tdata  = d;
    tuser  = u;
    tlast  = l;
    tvalid = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!tready && n < 1000);
    if (!tready) fail_now("send_timeout");
    @(posedge clk);
    #1;
    tvalid = 1'b0;
    tuser  = 1'b0;
    tlast  = 1'b0;
  endtask

  task automatic push_pads(input int from);
    for (int p = from; p < 8; p++) exp_w.push_back('{d: 64'h0, s: 8'h00, l: (p == 7)});
  endtask

  // kind 0: clean; 1: tlast at (el,ew); 2: stop before (el,ew), which the next frame's SOF hits.
  task automatic send_frame(input int tag, input bit wr, input logic [31:0] base,
                            input int kind, input int el, input int ew);
    bit          writing;
    logic [63:0] d;
    logic        last;
    writing = wr;
    for (int l = 0; l < 4; l++) begin
      for (int w = 0; w < 16; w++) begin
        d    = {16'hA5A5, 16'(tag), 16'(l), 16'(w)};
        last = (w == 15);
        if (kind == 2 && l == el && w == ew) begin
          push_pads(w % 8);
          return;
        end
        if (kind == 1 && l == el && w == ew) last = 1'b1;
        if (writing && (w % 8) == 0) begin
          exp_aw.push_back(base + 32'(l * 128 + w * 8));
          exp_aw_total++;
        end
        if (writing) exp_w.push_back('{d: d, s: 8'hFF, l: ((w % 8) == 7)});
        send(d, (l == 0 && w == 0), last);
        if (kind == 1 && writing && l == el && w == ew) begin
          push_pads(w % 8 + 1);
          writing = 1'b0;
        end
      end
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((exp_aw.size() != 0 || exp_w.size() != 0 || bq.size() != 0 || bvalid) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) fail_now("drain_timeout");
    repeat (4) @(negedge clk);
  endtask

  task automatic pulse_rd();
    @(posedge clk);
    #1 rd_done = 1'b1;
    @(posedge clk);
    #1 rd_done = 1'b0;
  endtask

  task automatic check_counts(string phase);
    check({phase, "_wr_done_cnt"}, 64'(done_cnt), 64'(exp_done));
    check({phase, "_drop_cnt"}, 64'(drop_cnt), 64'(exp_drop));
    check({phase, "_sync_err_cnt"}, 64'(err_cnt), 64'(exp_err));
    check({phase, "_aw_total"}, 64'(aw_total), 64'(exp_aw_total));
  endtask

  initial begin
    #900000;
    fail_now("global_watchdog");
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check("reset_valids", {awvalid, wvalid, tready}, 3'b000);
    check("reset_strobes", {wr_done, frame_drop, sync_err}, 3'b000);
    check("reset_bready", 64'(bready), 64'd1);
    check("reset_read_tied", {arvalid, rready}, 2'b00);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_tready", 64'(tready), 64'd1);

    // 1: clean frame at 0x1000
    send_frame(1, 1, 32'h1000, 0, 0, 0);
    exp_done++;
    wait_idle();
    check_counts("clean");
    pulse_rd();

    // 2: rotation 0x1200, 0x1400, back to 0x1000
    send_frame(2, 1, 32'h1200, 0, 0, 0);
    exp_done++;
    wait_idle();
    pulse_rd();
    send_frame(3, 1, 32'h1400, 0, 0, 0);
    exp_done++;
    wait_idle();
    pulse_rd();
    send_frame(4, 1, 32'h1000, 0, 0, 0);
    exp_done++;
    wait_idle();
    pulse_rd();
    check_counts("rotation");

    // 3: buffer full after reset, 4th frame dropped
    @(posedge clk);
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    send_frame(5, 1, 32'h1000, 0, 0, 0);
    wait_idle();
    send_frame(6, 1, 32'h1200, 0, 0, 0);
    wait_idle();
    send_frame(7, 1, 32'h1400, 0, 0, 0);
    wait_idle();
    exp_done += 3;
    send_frame(8, 0, 32'h0, 0, 0, 0);
    exp_drop++;
    wait_idle();
    check_counts("full");
    pulse_rd();
    pulse_rd();

    // 4: early tlast on word 5 of line 2, then same buffer reused
    send_frame(9, 1, 32'h1000, 1, 2, 5);
    exp_err++;
    wait_idle();
    check_counts("early_tlast");
    send_frame(10, 1, 32'h1000, 0, 0, 0);
    exp_done++;
    wait_idle();
    check_counts("after_early_tlast");
    pulse_rd();

    // 5: mid-frame SOF on word 3 of line 1, new frame at the same base
    send_frame(11, 1, 32'h1200, 2, 1, 3);
    send_frame(12, 1, 32'h1200, 0, 0, 0);
    exp_err++;
    exp_done++;
    wait_idle();
    check_counts("mid_sof");
    pulse_rd();

    // 6: backpressure on AW, W and B
    aw_delay = 5;
    b_delay  = 20;
    wr_pat   = 1'b1;
    send_frame(13, 1, 32'h1400, 0, 0, 0);
    exp_done++;
    wait_idle();
    check_counts("backpressure");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
